// File: rtl/crc_code_pkg.sv
// Shared constants and types for the CRC code path (serial decoder and encoder).
//   DEF_DATA_WIDTH / DEF_CRC_WIDTH : default payload and check widths
//   DEF_POLY / DEF_INIT            : generator polynomial (no implicit top term) and LFSR seed
//   DEF_N                          : default codeword width
//   state_t                        : serial checker FSM states
package crc_code_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CRC_WIDTH  = 8;
  localparam logic [DEF_CRC_WIDTH-1:0] DEF_POLY = 8'h07;
  localparam logic [DEF_CRC_WIDTH-1:0] DEF_INIT = 8'h00;
  localparam int DEF_N = DEF_DATA_WIDTH + DEF_CRC_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/crc_code_lfsr_step.sv
// One MSB-first step of a Galois CRC LFSR (combinational).
//   lfsr      in  current remainder
//   in_bit    in  next message bit
//   next_lfsr out remainder after absorbing in_bit: (lfsr*x + in_bit*x^W) mod POLY
module crc_code_lfsr_step
  import crc_code_pkg::*;
#(
  parameter int                    CRC_WIDTH = DEF_CRC_WIDTH,
  parameter logic [CRC_WIDTH-1:0]  POLY      = DEF_POLY
) (
  input  logic [CRC_WIDTH-1:0] lfsr,
  input  logic                 in_bit,
  output logic [CRC_WIDTH-1:0] next_lfsr
);

  logic fb;

  assign fb        = in_bit ^ lfsr[CRC_WIDTH-1];
  assign next_lfsr = {lfsr[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_code_serial_decoder.sv
// Serial CRC checker for the read path. Captures a stored codeword {data, crc},
// shifts it MSB-first through a Galois LFSR and reports the remainder.
//   clk, rst       rising-edge clock, synchronous active-low reset
//   load_en        capture codeword_in and start a new check (wins over shift_en)
//   shift_en       advance the check by one codeword bit
//   codeword_in    {data, crc} read from memory
//   data_out       payload captured at load
//   syndrome       LFSR remainder, valid from the check_done cycle on
//   crc_error      syndrome != 0, sticky until the next load or reset
//   check_done     one-cycle completion pulse
//   decoder_busy   high while bits are still being shifted
module crc_code_serial_decoder
  import crc_code_pkg::*;
#(
  parameter int                   DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                   CRC_WIDTH  = DEF_CRC_WIDTH,
  parameter logic [CRC_WIDTH-1:0] POLY       = DEF_POLY,
  parameter logic [CRC_WIDTH-1:0] INIT       = DEF_INIT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_en,
  input  logic                            shift_en,
  input  logic [DATA_WIDTH+CRC_WIDTH-1:0] codeword_in,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [CRC_WIDTH-1:0]            syndrome,
  output logic                            crc_error,
  output logic                            check_done,
  output logic                            decoder_busy
);

  localparam int N     = DATA_WIDTH + CRC_WIDTH;
  localparam int CNT_W = $clog2(N);

  state_t               state;
  state_t               next_state;
  logic [N-1:0]         shreg;
  logic [CRC_WIDTH-1:0] lfsr;
  logic [CRC_WIDTH-1:0] lfsr_next;
  logic [CNT_W-1:0]     cnt;
  logic                 do_load;
  logic                 do_shift;
  logic                 last_shift;

  crc_code_lfsr_step #(
    .CRC_WIDTH (CRC_WIDTH),
    .POLY      (POLY)
  ) u_step (
    .lfsr      (lfsr),
    .in_bit    (shreg[N-1]),
    .next_lfsr (lfsr_next)
  );

  // Next-state decode: a load restarts the check from any state, so it is
  // resolved before the per-state behaviour.
  always_comb begin
    next_state = state;
    do_load    = load_en;
    do_shift   = 1'b0;
    last_shift = 1'b0;
    if (load_en) begin
      next_state = SHIFT;
    end else begin
      case (state)
        IDLE:  next_state = IDLE;
        SHIFT: begin
          if (shift_en) begin
            do_shift = 1'b1;
            if (cnt == CNT_W'(N - 1)) begin
              last_shift = 1'b1;
              next_state = DONE;
            end
          end
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Registered stage: state, datapath and the decoded status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      shreg        <= '0;
      lfsr         <= '0;
      cnt          <= '0;
      data_out     <= '0;
      crc_error    <= 1'b0;
      check_done   <= 1'b0;
      decoder_busy <= 1'b0;
    end else begin
      state        <= next_state;
      check_done   <= (next_state == DONE);
      decoder_busy <= (next_state == SHIFT);
      if (do_load) begin
        shreg     <= codeword_in;
        lfsr      <= INIT;
        cnt       <= '0;
        data_out  <= codeword_in[N-1:CRC_WIDTH];
        crc_error <= 1'b0;
      end else if (do_shift) begin
        shreg <= {shreg[N-2:0], 1'b0};
        lfsr  <= lfsr_next;
        cnt   <= cnt + 1'b1;
        // The flag is taken from the final remainder so it is valid together with check_done.
        if (last_shift) crc_error <= (lfsr_next != '0);
      end
    end
  end

  // The LFSR only moves while shifting, so it holds the final remainder afterwards.
  assign syndrome = lfsr;

endmodule

// File: tb/tb_crc_code_serial_decoder.sv
module tb_crc_code_serial_decoder;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int N  = DW + CW;
  localparam logic [CW-1:0] P = 8'h07;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic          shift_en;
  logic [N-1:0]  codeword_in;
  logic [DW-1:0] data_out;
  logic [CW-1:0] syndrome;
  logic          crc_error;
  logic          check_done;
  logic          decoder_busy;

  int n_checks = 0;
  int n_err    = 0;

  // x^k mod P for every codeword bit position shifted up by the CRC width
  logic [CW-1:0] pw [0:N+CW-1];

  always #5 clk = ~clk;

  crc_code_serial_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .shift_en     (shift_en),
    .codeword_in  (codeword_in),
    .data_out     (data_out),
    .syndrome     (syndrome),
    .crc_error    (crc_error),
    .check_done   (check_done),
    .decoder_busy (decoder_busy)
  );

  function automatic logic [CW-1:0] mulx(input logic [CW-1:0] r);
    logic [CW-1:0] s;
    s = {r[CW-2:0], 1'b0};
    if (r[CW-1]) s = s ^ P;
    return s;
  endfunction

  // Syndrome of a codeword C: C(x)*x^CW mod P, by linearity over its set bits.
  function automatic logic [CW-1:0] syn_model(input logic [N-1:0] cw);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) if (cw[i]) s = s ^ pw[i+CW];
    return s;
  endfunction

  // Check bits that make {d, crc} a valid codeword: D(x)*x^CW mod P.
  function automatic logic [CW-1:0] crc_model(input logic [DW-1:0] d);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < DW; i++) if (d[i]) s = s ^ pw[i+CW];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_n(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      shift_en = 1'b1;
      tick();
      if (check_done) dones++;
    end
    shift_en = 1'b0;
  endtask

  // Load cw, then shift like the controller, optionally stalling stall_len
  // cycles once stall_at shifts have been accepted. Checks latency, the
  // single completion pulse, the result at completion and the held result.
  task automatic check_word(input string tag, input logic [N-1:0] cw, input logic [CW-1:0] exp_syn,
                            input int stall_at, input int stall_len, input bit with_shift);
    int dc, dn, shifts, stalled, exp_dc;
    bit busy_ok;
    logic [CW-1:0] syn_d;
    logic err_d;
    logic [DW-1:0] dat_d;
    dc = -1; dn = 0; shifts = 0; stalled = 0; busy_ok = 1'b1;
    syn_d = '0; err_d = 1'b0; dat_d = '0;
    exp_dc = N + 1 + ((stall_at >= 0) ? stall_len : 0);
    codeword_in = cw;
    load_en     = 1'b1;
    shift_en    = with_shift;
    tick();
    load_en  = 1'b0;
    shift_en = 1'b0;
    for (int c = 1; c <= exp_dc + 3; c++) begin
      if (check_done) begin
        dn++;
        if (dc < 0) begin
          dc = c; syn_d = syndrome; err_d = crc_error; dat_d = data_out;
        end
      end
      if (shifts < N) begin
        if (shifts == stall_at && stalled < stall_len) begin
          shift_en = 1'b0;
          stalled++;
          if (!decoder_busy) busy_ok = 1'b0;
        end else begin
          shift_en = 1'b1;
          shifts++;
        end
      end else begin
        shift_en = 1'b0;
      end
      tick();
    end
    shift_en = 1'b0;
    chk({tag, "_done_cycle"}, 64'(dc), 64'(exp_dc));
    chk({tag, "_done_count"}, 64'(dn), 64'd1);
    chk({tag, "_syndrome"}, 64'(syn_d), 64'(exp_syn));
    chk({tag, "_crc_error"}, 64'(err_d), 64'(exp_syn != '0));
    chk({tag, "_data_out"}, 64'(dat_d), 64'(cw[N-1:CW]));
    chk({tag, "_syn_hold"}, 64'(syndrome), 64'(exp_syn));
    chk({tag, "_err_hold"}, 64'(crc_error), 64'(exp_syn != '0));
    chk({tag, "_idle_busy"}, 64'(decoder_busy), 64'd0);
    if (stall_at >= 0 && stall_len > 0) chk({tag, "_stall_busy"}, 64'(busy_ok), 64'd1);
  endtask

  initial begin
    logic [N-1:0]  cw2;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    int dones;

    pw[0] = 8'h01;
    for (int k = 1; k < N + CW; k++) pw[k] = mulx(pw[k-1]);

    rst = 1'b0; load_en = 1'b0; shift_en = 1'b0; codeword_in = '0;
    repeat (3) tick();
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_syndrome", 64'(syndrome), 64'd0);
    chk("rst_crc_error", 64'(crc_error), 64'd0);
    chk("rst_check_done", 64'(check_done), 64'd0);
    chk("rst_busy", 64'(decoder_busy), 64'd0);
    rst = 1'b1;
    tick();

    cw2 = {32'h0000_0001, 8'h07};
    check_word("t1_zero", {32'h0000_0000, 8'h00}, 8'h00, -1, 0, 1'b0);
    check_word("t2_valid", cw2, 8'h00, -1, 0, 1'b0);
    check_word("t3_flip", {32'h0000_0001, 8'h06}, 8'h07, -1, 0, 1'b0);
    check_word("t4_stall", cw2, 8'h00, 10, 5, 1'b0);

    // abort: load word A, 12 shifts, then reload (with shift_en also high)
    codeword_in = {32'hA5A5_1234, 8'h5C};
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    shift_n(12, dones);
    chk("t5_abort_no_done", 64'(dones), 64'd0);
    check_word("t5_reload", cw2, 8'h00, -1, 0, 1'b1);

    // reset mid-check
    codeword_in = {32'hFFFF_0000, 8'hAB};
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    shift_n(20, dones);
    rst = 1'b0; shift_en = 1'b1;
    tick();
    rst = 1'b1; shift_en = 1'b0;
    chk("t6_data_out", 64'(data_out), 64'd0);
    chk("t6_syndrome", 64'(syndrome), 64'd0);
    chk("t6_crc_error", 64'(crc_error), 64'd0);
    chk("t6_check_done", 64'(check_done), 64'd0);
    chk("t6_busy", 64'(decoder_busy), 64'd0);
    shift_n(45, dones);
    chk("t6_no_done", 64'(dones), 64'd0);
    chk("t6_idle_busy", 64'(decoder_busy), 64'd0);
    chk("t6_idle_syn", 64'(syndrome), 64'd0);

    // load taken in the DONE cycle
    codeword_in = {32'h1234_5678, 8'h00};
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    shift_n(N, dones);
    chk("t7_done_pulse", 64'(check_done), 64'd1);
    chk("t7_done_syn", 64'(syndrome), 64'(syn_model({32'h1234_5678, 8'h00})));
    d = 32'hCAFE_F00D;
    check_word("t7_load_in_done", {d, crc_model(d)}, 8'h00, -1, 0, 1'b0);

    // randomized words, alternating valid and corrupted check bits
    for (int k = 0; k < 10; k++) begin
      d = $urandom;
      c = crc_model(d);
      if (k % 2 == 1) c = c ^ 8'($urandom_range(1, 255));
      check_word($sformatf("rnd%0d", k), {d, c}, syn_model({d, c}),
                 int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
